// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared types and widths for the SDRAM burst arbiter slice.
package sdram_burst_arbiter_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;

    // state | meaning
    // IDLE  | waiting for SDRAM init to complete
    // ARB   | choosing the next burst; one cycle minimum between bursts
    // WRITE | write burst granted, wr_req held until wr_end
    // READ  | read burst granted, rd_req held until rd_end
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } grant_t;

    // Read FIFO can absorb a full burst when count+len stays within 2**LEN_W-1,
    // i.e. the (LEN_W+1)-bit sum does not carry into its top bit.
    function automatic logic rd_has_room(input logic [LEN_W-1:0] num,
                                         input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, num} + {1'b0, len};
        return !sum[LEN_W];
    endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// FIFO-level / window / engine handshake bundle around the burst arbiter.
interface sdram_burst_arbiter_if;
    import sdram_burst_arbiter_pkg::*;

    logic              init_end;
    logic [LEN_W-1:0]  wr_fifo_num;
    logic [LEN_W-1:0]  rd_fifo_num;
    logic [ADDR_W-1:0] wr_b_addr;
    logic [ADDR_W-1:0] wr_e_addr;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [ADDR_W-1:0] rd_e_addr;
    logic [LEN_W-1:0]  wr_burst_len;
    logic [LEN_W-1:0]  rd_burst_len;
    logic              rd_valid;
    logic              wr_rst;
    logic              rd_rst;
    logic              wr_end;
    logic              rd_end;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_frame_end;
    logic              rd_frame_end;

    modport slave (
        input  init_end, wr_fifo_num, rd_fifo_num, wr_b_addr, wr_e_addr,
               rd_b_addr, rd_e_addr, wr_burst_len, rd_burst_len, rd_valid,
               wr_rst, rd_rst, wr_end, rd_end,
        output wr_req, wr_addr, rd_req, rd_addr, wr_frame_end, rd_frame_end
    );

    modport master (
        output init_end, wr_fifo_num, rd_fifo_num, wr_b_addr, wr_e_addr,
               rd_b_addr, rd_e_addr, wr_burst_len, rd_burst_len, rd_valid,
               wr_rst, rd_rst, wr_end, rd_end,
        input  wr_req, wr_addr, rd_req, rd_addr, wr_frame_end, rd_frame_end
    );

endinterface

// File: rtl/sdram_burst_arbiter_addr_gen.sv
// Burst start-address generator: steps by the burst length and wraps inside
// [base, end). A reload request during the path's own burst is deferred to
// the end of that burst and then overrides the step.
module sdram_burst_arbiter_addr_gen
    import sdram_burst_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [ADDR_W-1:0] i_e_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_busy,
    input  logic              i_step,
    input  logic              i_reload,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_frame_end
);

    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic              r_frame_end;
    logic [ADDR_W:0]   w_nxt;
    logic              w_wrap;

    assign w_nxt  = {1'b0, r_addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, i_len};
    assign w_wrap = (w_nxt >= {1'b0, i_e_addr});

    // Address register, deferred-reload flag and one-cycle wrap pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= i_b_addr;
            r_pend      <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            if (i_step) begin
                r_pend <= 1'b0;
                if (r_pend || i_reload) begin
                    r_addr <= i_b_addr;
                end else if (w_wrap) begin
                    r_addr      <= i_b_addr;
                    r_frame_end <= 1'b1;
                end else begin
                    r_addr <= w_nxt[ADDR_W-1:0];
                end
            end else if (i_reload) begin
                if (i_busy) begin
                    r_pend <= 1'b1;
                end else begin
                    r_addr <= i_b_addr;
                end
            end
        end
    end

    assign o_addr      = r_addr;
    assign o_frame_end = r_frame_end;

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Grants the single SDRAM command engine to the write or read path, one burst
// at a time, round-robin on contention, with one ARB cycle after every burst.
module sdram_burst_arbiter
    import sdram_burst_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_burst_arbiter_if.slave bus
);

    state_t r_state;
    state_t w_next_state;
    grant_t r_last_grant;
    logic   w_wr_elig;
    logic   w_rd_elig;
    logic   w_wr_req;
    logic   w_rd_req;
    logic   w_wr_step;
    logic   w_rd_step;

    assign w_wr_elig = (bus.wr_burst_len != '0) && (bus.wr_fifo_num >= bus.wr_burst_len);
    assign w_rd_elig = bus.rd_valid && (bus.rd_burst_len != '0)
                       && rd_has_room(bus.rd_fifo_num, bus.rd_burst_len);

    assign w_wr_step = (r_state == ST_WRITE) && bus.wr_end;
    assign w_rd_step = (r_state == ST_READ) && bus.rd_end;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and request decode.
    always_comb begin
        w_next_state = r_state;
        w_wr_req     = 1'b0;
        w_rd_req     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.init_end) w_next_state = ST_ARB;
            end
            ST_ARB: begin
                if (w_wr_elig && w_rd_elig) begin
                    w_next_state = (r_last_grant == GNT_READ) ? ST_WRITE : ST_READ;
                end else if (w_wr_elig) begin
                    w_next_state = ST_WRITE;
                end else if (w_rd_elig) begin
                    w_next_state = ST_READ;
                end
            end
            ST_WRITE: begin
                w_wr_req = 1'b1;
                if (bus.wr_end) w_next_state = ST_ARB;
            end
            ST_READ: begin
                w_rd_req = 1'b1;
                if (bus.rd_end) w_next_state = ST_ARB;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Remember which path finished last for round-robin tie-breaks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GNT_READ;
        end else if (w_wr_step) begin
            r_last_grant <= GNT_WRITE;
        end else if (w_rd_step) begin
            r_last_grant <= GNT_READ;
        end
    end

    assign bus.wr_req = w_wr_req;
    assign bus.rd_req = w_rd_req;

    sdram_burst_arbiter_addr_gen u_wr_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_b_addr    (bus.wr_b_addr),
        .i_e_addr    (bus.wr_e_addr),
        .i_len       (bus.wr_burst_len),
        .i_busy      (r_state == ST_WRITE),
        .i_step      (w_wr_step),
        .i_reload    (bus.wr_rst),
        .o_addr      (bus.wr_addr),
        .o_frame_end (bus.wr_frame_end)
    );

    sdram_burst_arbiter_addr_gen u_rd_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_b_addr    (bus.rd_b_addr),
        .i_e_addr    (bus.rd_e_addr),
        .i_len       (bus.rd_burst_len),
        .i_busy      (r_state == ST_READ),
        .i_step      (w_rd_step),
        .i_reload    (bus.rd_rst),
        .o_addr      (bus.rd_addr),
        .o_frame_end (bus.rd_frame_end)
    );

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: arbitration vector table plus
// hand-written burst sequences for wrap, reload and reset corner cases.
module tb_sdram_burst_arbiter;
    import sdram_burst_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] WR_B = 24'd0;
    localparam logic [ADDR_W-1:0] WR_E = 24'd786432;
    localparam logic [ADDR_W-1:0] RD_B = 24'h100000;
    localparam logic [ADDR_W-1:0] RD_E = 24'h101000;

    typedef struct {
        logic [LEN_W-1:0] wr_num;
        logic [LEN_W-1:0] rd_num;
        logic [LEN_W-1:0] wr_len;
        logic [LEN_W-1:0] rd_len;
        logic             rd_valid;
        logic             exp_w;
        logic             exp_r;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   overlap  = 0;
    int   wr_frames = 0;
    vec_t vecs[11];

    sdram_burst_arbiter_if bus();

    sdram_burst_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_req && bus.rd_req) overlap++;
        if (bus.wr_frame_end) wr_frames++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(int wn, int rn, int wl, int rl, bit rv, bit ew, bit er);
        vec_t v;
        v.wr_num   = wn[LEN_W-1:0];
        v.rd_num   = rn[LEN_W-1:0];
        v.wr_len   = wl[LEN_W-1:0];
        v.rd_len   = rl[LEN_W-1:0];
        v.rd_valid = rv;
        v.exp_w    = ew;
        v.exp_r    = er;
        return v;
    endfunction

    task automatic wait_req(input bit is_wr, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (is_wr ? bus.wr_req : bus.rd_req) got = 1'b1;
            else tick();
        end
        check({name, "_req_seen"}, 64'(got), 64'd1);
    endtask

    task automatic wait_any(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (bus.wr_req || bus.rd_req) got = 1'b1;
            else tick();
        end
        check({name, "_grant_seen"}, 64'(got), 64'd1);
    endtask

    // Completes whichever burst is active; optionally makes both paths ineligible first.
    task automatic end_burst(input bit idle);
        if (idle) begin
            bus.wr_fifo_num = '0;
            bus.rd_valid    = 1'b0;
        end
        if (bus.wr_req) bus.wr_end = 1'b1;
        else if (bus.rd_req) bus.rd_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        bus.rd_end = 1'b0;
    endtask

    initial begin
        int  f0;
        bit  got;
        bit  exp_w;

        vecs[0]  = mk(600,  0,   512,  512, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(0,    0,   512,  512, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(512,  0,   512,  512, 1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(512,  0,   512,  512, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(511,  0,   512,  512, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1023, 0,   0,    512, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(0,    511, 512,  512, 1'b1, 1'b0, 1'b1);
        vecs[7]  = mk(0,    512, 512,  512, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(0,    0,   512,  0,   1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(512,  0,   512,  512, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(1023, 0,   1023, 1,   1'b1, 1'b0, 1'b1);

        bus.init_end     = 1'b0;
        bus.wr_fifo_num  = 10'd600;
        bus.rd_fifo_num  = 10'd0;
        bus.wr_b_addr    = WR_B;
        bus.wr_e_addr    = WR_E;
        bus.rd_b_addr    = RD_B;
        bus.rd_e_addr    = RD_E;
        bus.wr_burst_len = 10'd512;
        bus.rd_burst_len = 10'd512;
        bus.rd_valid     = 1'b0;
        bus.wr_rst       = 1'b0;
        bus.rd_rst       = 1'b0;
        bus.wr_end       = 1'b0;
        bus.rd_end       = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_wr_req", 64'(bus.wr_req), 64'd0);
        check("rst_rd_req", 64'(bus.rd_req), 64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'(WR_B));
        check("rst_rd_addr", 64'(bus.rd_addr), 64'(RD_B));
        check("rst_frames", 64'({bus.wr_frame_end, bus.rd_frame_end}), 64'd0);
        rst_n = 1'b1;

        // No grant before init_end, then grant within 3 clocks
        repeat (4) tick();
        check("pre_init_wr_req", 64'(bus.wr_req), 64'd0);
        bus.init_end = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3 && !got; i++) begin
            tick();
            if (bus.wr_req) got = 1'b1;
        end
        check("init_grant_3clk", 64'(got), 64'd1);
        check("init_wr_addr", 64'(bus.wr_addr), 64'd0);

        // Full frame of 1536 write bursts, wrap back to base
        f0 = wr_frames;
        for (int k = 0; k < 1536; k++) begin
            wait_req(1'b1, "frame");
            check($sformatf("frame_addr_%0d", k), 64'(bus.wr_addr), 64'(k * 512));
            end_burst(1'b0);
        end
        check("wrap_frame_end_pulse", 64'(bus.wr_frame_end), 64'd1);
        check("wrap_wr_addr", 64'(bus.wr_addr), 64'(WR_B));
        wait_req(1'b1, "post_wrap");
        check("wrap_frame_count", 64'(wr_frames - f0), 64'd1);
        check("post_wrap_addr", 64'(bus.wr_addr), 64'd0);
        end_burst(1'b1);

        // Arbitration table
        for (int i = 0; i < 11; i++) begin
            bus.wr_fifo_num  = vecs[i].wr_num;
            bus.rd_fifo_num  = vecs[i].rd_num;
            bus.wr_burst_len = vecs[i].wr_len;
            bus.rd_burst_len = vecs[i].rd_len;
            bus.rd_valid     = vecs[i].rd_valid;
            tick();
            tick();
            check($sformatf("vec%0d_wr_req", i), 64'(bus.wr_req), 64'(vecs[i].exp_w));
            check($sformatf("vec%0d_rd_req", i), 64'(bus.rd_req), 64'(vecs[i].exp_r));
            end_burst(1'b1);
        end

        // Both held eligible: W,R,W,R
        bus.wr_fifo_num  = 10'd512;
        bus.rd_fifo_num  = 10'd0;
        bus.wr_burst_len = 10'd512;
        bus.rd_burst_len = 10'd512;
        bus.rd_valid     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = (i % 2 == 0);
            wait_any($sformatf("rr%0d", i));
            check($sformatf("rr%0d_wr_req", i), 64'(bus.wr_req), 64'(exp_w));
            check($sformatf("rr%0d_rd_req", i), 64'(bus.rd_req), 64'(!exp_w));
            end_burst(i == 3);
        end

        // Read path disabled or zero-length: writes only
        bus.wr_fifo_num  = 10'd512;
        bus.rd_valid     = 1'b0;
        bus.rd_burst_len = 10'd512;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.rd_valid     = 1'b1;
                bus.rd_burst_len = 10'd0;
            end
            wait_any($sformatf("wonly%0d", i));
            check($sformatf("wonly%0d_wr_req", i), 64'(bus.wr_req), 64'd1);
            check($sformatf("wonly%0d_rd_req", i), 64'(bus.rd_req), 64'd0);
            end_burst(i == 3);
        end

        // wr_rst outside a burst reloads next cycle; inside a burst it is deferred
        bus.wr_rst = 1'b1;
        tick();
        bus.wr_rst = 1'b0;
        check("idle_reload_wr_addr", 64'(bus.wr_addr), 64'(WR_B));
        bus.wr_fifo_num = 10'd512;
        wait_req(1'b1, "b0");
        check("b0_addr", 64'(bus.wr_addr), 64'd0);
        end_burst(1'b0);
        wait_req(1'b1, "b1");
        check("b1_addr", 64'(bus.wr_addr), 64'd512);
        end_burst(1'b0);
        wait_req(1'b1, "b2");
        check("b2_addr", 64'(bus.wr_addr), 64'd1024);
        bus.wr_fifo_num = 10'd0;
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        check("stray_rd_end_rd_addr", 64'(bus.rd_addr), 64'(RD_B + 24'd2561));
        check("stray_rd_end_wr_req", 64'(bus.wr_req), 64'd1);
        bus.wr_rst = 1'b1;
        tick();
        bus.wr_rst = 1'b0;
        check("pending_addr_stable", 64'(bus.wr_addr), 64'd1024);
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        check("pending_no_frame_end", 64'(bus.wr_frame_end), 64'd0);
        check("pending_reload_addr", 64'(bus.wr_addr), 64'(WR_B));
        check("pending_rd_addr_kept", 64'(bus.rd_addr), 64'(RD_B + 24'd2561));

        // rst_n pulse mid-read
        bus.rd_burst_len = 10'd512;
        bus.rd_fifo_num  = 10'd0;
        bus.rd_valid     = 1'b1;
        wait_req(1'b0, "pre_rst_read");
        rst_n        = 1'b0;
        bus.init_end = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_rd_req", 64'(bus.rd_req), 64'd0);
        check("midrst_rd_addr", 64'(bus.rd_addr), 64'(RD_B));
        repeat (3) tick();
        check("midrst_idle_no_req", 64'({bus.wr_req, bus.rd_req}), 64'd0);
        bus.wr_fifo_num = 10'd512;
        bus.init_end    = 1'b1;
        wait_any("post_rst");
        check("post_rst_tie_write_first", 64'(bus.wr_req), 64'd1);
        end_burst(1'b1);
        tick();

        check("never_both_req", 64'(overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
